// File: rtl/fpnew_pkg.sv
// FP format descriptors, classification info and the FCLASS mask encoding.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    int unsigned exp_bits;
    int unsigned man_bits;
  } fp_encoding_t;

  localparam fp_encoding_t [0:4] FP_ENCODINGS = '{
    '{8, 23}, '{11, 52}, '{5, 10}, '{5, 2}, '{8, 7}
  };

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  // One-hot RISC-V FCLASS result bits.
  typedef enum logic [9:0] {
    NEGINF     = 10'h001,
    NEGNORM    = 10'h002,
    NEGSUBNORM = 10'h004,
    NEGZERO    = 10'h008,
    POSZERO    = 10'h010,
    POSSUBNORM = 10'h020,
    POSNORM    = 10'h040,
    POSINF     = 10'h080,
    SNAN       = 10'h100,
    QNAN       = 10'h200
  } classmask_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    return FP_ENCODINGS[fmt].exp_bits;
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    return FP_ENCODINGS[fmt].man_bits;
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return FP_ENCODINGS[fmt].exp_bits + FP_ENCODINGS[fmt].man_bits + 1;
  endfunction

  // NaN is tested first so unboxed operands (flagged as quiet NaN) never
  // fall through to a sign-dependent class.
  function automatic classmask_e fclass_mask(fp_info_t info, logic sign);
    if (info.is_nan)            return info.is_signalling ? SNAN : QNAN;
    else if (info.is_inf)       return sign ? NEGINF : POSINF;
    else if (info.is_normal)    return sign ? NEGNORM : POSNORM;
    else if (info.is_subnormal) return sign ? NEGSUBNORM : POSSUBNORM;
    else                        return sign ? NEGZERO : POSZERO;
  endfunction

endpackage

// File: rtl/fpnew_classifier.sv
// Decodes exponent/mantissa of each operand into fp_info_t class flags.
// Latency: combinational.
// Backpressure: none, pure function of the operands.
module fpnew_classifier
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned NumOperands = 1,
  parameter int unsigned WIDTH       = fp_width(FpFormat)
) (
  input  logic [NumOperands-1:0][WIDTH-1:0] operands_i,
  input  logic [NumOperands-1:0]            is_boxed_i,
  output fp_info_t [NumOperands-1:0]        info_o
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = man_bits(FpFormat);

  for (genvar op = 0; op < int'(NumOperands); op++) begin : gen_op
    logic [EXP_BITS-1:0] exp_w;
    logic [MAN_BITS-1:0] man_w;
    logic                boxed_w, exp_ones_w, exp_zero_w, man_zero_w;
    logic                unused_sign;

    assign exp_w       = operands_i[op][WIDTH-2 -: EXP_BITS];
    assign man_w       = operands_i[op][MAN_BITS-1:0];
    assign unused_sign = operands_i[op][WIDTH-1];
    assign boxed_w     = is_boxed_i[op];
    assign exp_ones_w  = &exp_w;
    assign exp_zero_w  = ~|exp_w;
    assign man_zero_w  = ~|man_w;

    // An unboxed operand is treated as the canonical quiet NaN.
    assign info_o[op].is_normal     = boxed_w & ~exp_zero_w & ~exp_ones_w;
    assign info_o[op].is_subnormal  = boxed_w & exp_zero_w & ~man_zero_w;
    assign info_o[op].is_zero       = boxed_w & exp_zero_w & man_zero_w;
    assign info_o[op].is_inf        = boxed_w & exp_ones_w & man_zero_w;
    assign info_o[op].is_nan        = ~boxed_w | (exp_ones_w & ~man_zero_w);
    assign info_o[op].is_signalling = boxed_w & exp_ones_w & ~man_zero_w & ~man_w[MAN_BITS-1];
    assign info_o[op].is_quiet      = info_o[op].is_nan & ~info_o[op].is_signalling;
    assign info_o[op].is_boxed      = boxed_w;
  end

endmodule

// File: rtl/fpnew_fclass_pipe.sv
// Classifies an FP operand into the 10-bit FCLASS mask and pipelines it with a tag.
// Latency: NumPipeRegs cycles (0 = combinational pass-through).
// Backpressure: valid/ready per stage, bubbles collapse; flush drops all in-flight ops.
module fpnew_fclass_pipe
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = fp_format_e'(0),
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1,
  parameter int unsigned WIDTH       = fp_width(FpFormat)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WIDTH-1:0]    operand_i,
  input  logic                is_boxed_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [WIDTH-1:0]    result_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  fp_info_t info;

  fpnew_classifier #(
    .FpFormat   (FpFormat),
    .NumOperands(1)
  ) i_classifier (
    .operands_i(operand_i),
    .is_boxed_i(is_boxed_i),
    .info_o    (info)
  );

  // Index 0 is the combinational input side; index k>0 is pipeline register k.
  logic                stage_vld  [0:NumPipeRegs];
  logic                stage_rdy  [0:NumPipeRegs];
  logic [9:0]          stage_mask [0:NumPipeRegs];
  logic [TagWidth-1:0] stage_tag  [0:NumPipeRegs];

  assign stage_vld[0]  = in_valid_i;
  assign stage_mask[0] = fclass_mask(info, operand_i[WIDTH-1]);
  assign stage_tag[0]  = tag_i;

  // Ready ripples back from the output: a stage accepts when it is empty or drains.
  always_comb begin
    for (int k = 0; k <= int'(NumPipeRegs); k++) stage_rdy[k] = 1'b0;
    stage_rdy[NumPipeRegs] = out_ready_i;
    for (int k = int'(NumPipeRegs) - 1; k >= 0; k--)
      stage_rdy[k] = stage_rdy[k+1] | ~stage_vld[k+1];
  end

  for (genvar i = 0; i < int'(NumPipeRegs); i++) begin : gen_stage
    logic                vld_d, vld_q;
    logic [9:0]          mask_d, mask_q;
    logic [TagWidth-1:0] tag_d, tag_q;

    // Next-state: valid follows upstream when ready; data only moves on a transfer.
    always_comb begin
      vld_d  = vld_q;
      mask_d = mask_q;
      tag_d  = tag_q;
      if (stage_rdy[i]) vld_d = stage_vld[i];
      if (flush_i) vld_d = 1'b0;
      if (stage_vld[i] && stage_rdy[i]) begin
        mask_d = stage_mask[i];
        tag_d  = stage_tag[i];
      end
    end

    // Stage register, cleared asynchronously so in-flight ops vanish on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q  <= 1'b0;
        mask_q <= '0;
        tag_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        mask_q <= mask_d;
        tag_q  <= tag_d;
      end
    end

    assign stage_vld[i+1]  = vld_q;
    assign stage_mask[i+1] = mask_q;
    assign stage_tag[i+1]  = tag_q;
  end

  // Busy whenever any register stage holds an operation; the input side does not count.
  always_comb begin
    busy_o = 1'b0;
    for (int k = 1; k <= int'(NumPipeRegs); k++) busy_o = busy_o | stage_vld[k];
  end

  assign in_ready_o  = stage_rdy[0];
  assign out_valid_o = stage_vld[NumPipeRegs];
  assign tag_o       = stage_tag[NumPipeRegs];
  assign result_o    = {{(WIDTH-10){1'b0}}, stage_mask[NumPipeRegs]};

endmodule

// File: tb/tb_fpnew_fclass_pipe.sv
module tb_fpnew_fclass_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // dut1: NumPipeRegs=1
  logic [31:0] op1, res1;
  logic [1:0]  tag1, to1;
  logic        box1, iv1, ir1, fl1, ov1, ordy1, busy1;
  // dut2: NumPipeRegs=2
  logic [31:0] op2, res2;
  logic [1:0]  tag2, to2;
  logic        box2, iv2, ir2, fl2, ov2, ordy2, busy2;
  // dut0: NumPipeRegs=0
  logic [31:0] op0, res0;
  logic [1:0]  tag0, to0;
  logic        box0, iv0, ir0, fl0, ov0, ordy0, busy0;

  fpnew_fclass_pipe #(.NumPipeRegs(1), .TagWidth(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .operand_i(op1), .is_boxed_i(box1), .tag_i(tag1),
    .in_valid_i(iv1), .in_ready_o(ir1), .flush_i(fl1), .result_o(res1), .tag_o(to1),
    .out_valid_o(ov1), .out_ready_i(ordy1), .busy_o(busy1));

  fpnew_fclass_pipe #(.NumPipeRegs(2), .TagWidth(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .operand_i(op2), .is_boxed_i(box2), .tag_i(tag2),
    .in_valid_i(iv2), .in_ready_o(ir2), .flush_i(fl2), .result_o(res2), .tag_o(to2),
    .out_valid_o(ov2), .out_ready_i(ordy2), .busy_o(busy2));

  fpnew_fclass_pipe #(.NumPipeRegs(0), .TagWidth(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .operand_i(op0), .is_boxed_i(box0), .tag_i(tag0),
    .in_valid_i(iv0), .in_ready_o(ir0), .flush_i(fl0), .result_o(res0), .tag_o(to0),
    .out_valid_o(ov0), .out_ready_i(ordy0), .busy_o(busy0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] cls_op  [0:5] = '{32'hFF800000, 32'h00000000, 32'h80000001,
                                 32'h7F800001, 32'h7FC00000, 32'h3F800000};
  logic [31:0] cls_exp [0:5] = '{32'h001, 32'h010, 32'h004, 32'h100, 32'h200, 32'h040};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int nxt, sent;
    rst = 1'b1;
    op1 = '0; tag1 = '0; box1 = 1'b1; iv1 = 1'b0; fl1 = 1'b0; ordy1 = 1'b1;
    op2 = '0; tag2 = '0; box2 = 1'b1; iv2 = 1'b0; fl2 = 1'b0; ordy2 = 1'b1;
    op0 = '0; tag0 = '0; box0 = 1'b1; iv0 = 1'b0; fl0 = 1'b0; ordy0 = 1'b1;
    #1;
    // Reset state
    check("rst_ov1",   ov1,   0);
    check("rst_busy1", busy1, 0);
    check("rst_res1",  res1,  0);
    check("rst_tag1",  to1,   0);
    check("rst_ir1",   ir1,   1);
    check("rst_ov2",   ov2,   0);
    check("rst_ir2",   ir2,   1);
    check("rst_res2",  res2,  0);
    step(); step();
    rst = 1'b0;
    step();

    // Class vectors, one cycle latency, back-to-back
    iv1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      op1  = cls_op[k];
      tag1 = 2'(k);
      step();
      check("cls_res", res1, cls_exp[k]);
      check("cls_tag", to1, 32'(k % 4));
      check("cls_vld", ov1, 1);
    end
    // Unboxed operand is a quiet NaN
    box1 = 1'b0; op1 = 32'h3F800000; tag1 = 2'd0;
    step();
    check("unboxed", res1, 32'h200);
    box1 = 1'b1; iv1 = 1'b0;
    step();
    check("idle_ov1",   ov1,   0);
    check("idle_busy1", busy1, 0);

    // Flush discards an input accepted in the same cycle
    iv1 = 1'b1; fl1 = 1'b1; op1 = 32'h0;
    #1;
    check("flush_ir1", ir1, 1);
    step();
    iv1 = 1'b0; fl1 = 1'b0;
    check("flush_in_ov1",   ov1,   0);
    check("flush_in_busy1", busy1, 0);

    // Backpressure on NumPipeRegs=2
    ordy2 = 1'b0; iv2 = 1'b1; op2 = 32'h0; tag2 = 2'd0;
    #1; check("bp_ir_a", ir2, 1);
    step();
    tag2 = 2'd1;
    #1; check("bp_ir_b", ir2, 1);
    step();
    tag2 = 2'd2;
    #1;
    check("bp_full_ir", ir2, 0);
    check("bp_full_ov", ov2, 1);
    check("bp_full_tag", to2, 0);
    repeat (3) begin
      step();
      check("bp_hold_ov",  ov2,  1);
      check("bp_hold_tag", to2,  0);
      check("bp_hold_res", res2, 32'h010);
      check("bp_hold_ir",  ir2,  0);
    end
    nxt = 0; sent = 2;
    for (int c = 0; c < 12 && nxt < 4; c++) begin
      ordy2 = 1'b1;
      iv2   = (sent < 4);
      tag2  = 2'(sent);
      #1;
      if (ov2) begin
        check("bp_order", to2, 32'(nxt));
        nxt++;
      end
      if (iv2 && ir2) sent++;
      step();
    end
    iv2 = 1'b0;
    check("bp_count", nxt, 4);
    check("bp_sent",  sent, 4);
    check("bp_drain_ov",   ov2,   0);
    check("bp_drain_busy", busy2, 0);

    // Flush with two ops in flight plus a simultaneous input
    ordy2 = 1'b0; iv2 = 1'b1; tag2 = 2'd1;
    step();
    tag2 = 2'd2;
    step();
    tag2 = 2'd3; fl2 = 1'b1;
    #1;
    check("fl_ir_ungated", ir2,   0);
    check("fl_busy_pre",   busy2, 1);
    step();
    fl2 = 1'b0; iv2 = 1'b0; ordy2 = 1'b1;
    check("fl_ov",   ov2,   0);
    check("fl_busy", busy2, 0);
    repeat (3) begin
      step();
      check("fl_noout", ov2, 0);
    end

    // Asynchronous reset with two ops in flight
    ordy2 = 1'b0; iv2 = 1'b1; tag2 = 2'd1;
    step();
    tag2 = 2'd2;
    step();
    iv2 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ov",   ov2,   0);
    check("arst_ir",   ir2,   1);
    check("arst_busy", busy2, 0);
    #2;
    rst = 1'b0;
    step();
    ordy2 = 1'b1; iv2 = 1'b1; tag2 = 2'd1; op2 = 32'h3F800000;
    step();
    iv2 = 1'b0;
    check("post_rst_lat", ov2, 0);
    step();
    check("post_rst_ov",  ov2,  1);
    check("post_rst_res", res2, 32'h040);
    check("post_rst_tag", to2,  1);

    // Combinational pass-through
    op0 = 32'hBF800000; iv0 = 1'b1; ordy0 = 1'b1; tag0 = 2'd3;
    #1;
    check("np0_res",  res0,  32'h002);
    check("np0_ov",   ov0,   1);
    check("np0_tag",  to0,   3);
    check("np0_ir",   ir0,   1);
    check("np0_busy", busy0, 0);
    ordy0 = 1'b0;
    #1;
    check("np0_ir_low", ir0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
